ccw_mem_sched: RTL



---
 rtl/ccw_mem_sched_if.sv | 24 ++
 rtl/ccw_mem_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ccw_mem_sched_if.sv
// Channel memory-path handshake between the CCW memory scheduler and the memory port.
interface ccw_mem_sched_if;
  logic       mem_req_h;
  logic [1:0] mem_sel_h;
  logic [3:0] wd_req_h;
  logic       mem_wd_taken_h;
  logic       mem_err_h;

  modport master (
    output mem_req_h,
    output mem_sel_h,
    output wd_req_h,
    input  mem_wd_taken_h,
    input  mem_err_h
  );

  modport slave (
    input  mem_req_h,
    input  mem_sel_h,
    input  wd_req_h,
    output mem_wd_taken_h,
    output mem_err_h
  );
endinterface

// File: rtl/ccw_mem_sched.sv
// KL10 channel memory-cycle scheduler: arbitrates four requesters, sequences words,
// advances the channel buffer address on data words and aborts stalled cycles.
module ccw_mem_sched #(
  parameter int unsigned WC_W    = 11,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic            clk_ccw_h,
  input  logic            ch_mr_reset_b_h,
  input  logic            store_req_h,
  input  logic            ccwf_req_h,
  input  logic            act_flag_req_h,
  input  logic            xfer_req_h,
  input  logic [WC_W-1:0] xfer_wc_h,
  input  logic            ch_mb_req_inh_h,
  input  logic            diag_channel_clk_stop_h,
  ccw_mem_sched_if.master mem,
  output logic [2:0]      buf_adr_h,
  output logic            store_done_h,
  output logic            ccwf_done_h,
  output logic            act_done_h,
  output logic            xfer_done_h,
  output logic            err_req_h,
  output logic            busy_h
);

  localparam int unsigned WdogW = $clog2(TMO_CYC);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TMO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [1:0]       sel_q;
  logic [2:0]       nwords_q;
  logic [1:0]       idx_q;
  logic [WdogW-1:0] wdog_q;
  logic [2:0]       buf_adr_q;
  logic             mem_req_q;
  logic [3:0]       wd_req_q;
  logic [3:0]       done_q;
  logic             err_q;

  logic       grant;
  logic [1:0] grant_sel;
  logic [2:0] grant_nw;
  logic [2:0] xfer_nw;
  logic       last_word;

  // A data quadword moves at most four words, fewer when the count runs out.
  always_comb begin
    xfer_nw = (xfer_wc_h > WC_W'(3)) ? 3'd4 : xfer_wc_h[2:0];
  end

  always_comb begin
    grant     = 1'b0;
    grant_sel = 2'd0;
    grant_nw  = 3'd0;
    if (!ch_mb_req_inh_h) begin
      if (store_req_h) begin
        grant     = 1'b1;
        grant_sel = 2'd0;
        grant_nw  = 3'd2;
      end else if (ccwf_req_h) begin
        grant     = 1'b1;
        grant_sel = 2'd1;
        grant_nw  = 3'd1;
      end else if (act_flag_req_h) begin
        grant     = 1'b1;
        grant_sel = 2'd2;
        grant_nw  = 3'd1;
      end else if (xfer_req_h) begin
        grant     = 1'b1;
        grant_sel = 2'd3;
        grant_nw  = xfer_nw;
      end
    end
  end

  always_comb begin
    last_word = ({1'b0, idx_q} == (nwords_q - 3'd1));
  end

  always_ff @(posedge clk_ccw_h) begin
    if (ch_mr_reset_b_h) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      nwords_q  <= 3'd0;
      idx_q     <= 2'd0;
      wdog_q    <= '0;
      buf_adr_q <= 3'd0;
      mem_req_q <= 1'b0;
      wd_req_q  <= 4'd0;
      done_q    <= 4'd0;
      err_q     <= 1'b0;
    end else if (!diag_channel_clk_stop_h) begin
      done_q <= 4'd0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            sel_q    <= grant_sel;
            nwords_q <= grant_nw;
            idx_q    <= 2'd0;
            wdog_q   <= '0;
            if (grant_nw == 3'd0) begin
              state_q <= StDone;
              done_q  <= 4'b0001 << grant_sel;
            end else begin
              state_q   <= StBusy;
              mem_req_q <= 1'b1;
              wd_req_q  <= 4'b0001;
            end
          end
        end
        StBusy: begin
          // An error beats a coincident word-taken; that word is not counted.
          if (mem.mem_err_h) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            wd_req_q  <= 4'd0;
            err_q     <= 1'b1;
          end else if (mem.mem_wd_taken_h) begin
            wdog_q <= '0;
            if (sel_q == 2'd3) begin
              buf_adr_q <= buf_adr_q + 3'd1;
            end
            if (last_word) begin
              state_q   <= StDone;
              mem_req_q <= 1'b0;
              wd_req_q  <= 4'd0;
              done_q    <= 4'b0001 << sel_q;
            end else begin
              idx_q    <= idx_q + 2'd1;
              wd_req_q <= wd_req_q << 1;
            end
          end else if (wdog_q == WdogLast) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            wd_req_q  <= 4'd0;
            err_q     <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem.mem_req_h = mem_req_q;
  assign mem.mem_sel_h = sel_q;
  assign mem.wd_req_h  = wd_req_q;
  assign buf_adr_h     = buf_adr_q;
  assign store_done_h  = done_q[0];
  assign ccwf_done_h   = done_q[1];
  assign act_done_h    = done_q[2];
  assign xfer_done_h   = done_q[3];
  assign err_req_h     = err_q;
  assign busy_h        = (state_q != StIdle);

endmodule
